sipo_framer: RTL and testbench

Serial-in/parallel-out framer that sits directly downstream of the single-bit `d_ff` stage. It samples the registered serial bit on qualified clock edges and assembles fixed-length frames, MSB first. Each completed word is presented on a valid/ready handshake to the next stage. A one-word output buffer lets the next frame shift in while the current word waits for acceptance.

---
 rtl/sipo_pkg.sv | 25 ++
 rtl/sipo_framer_frame_counter.sv | 25 ++
 rtl/sipo_framer.sv | 146 ++++++++++++++
 tb/tb_sipo_framer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/sipo_pkg.sv
// sipo_pkg: shared types and sizing helpers for the sipo_framer block.
// Optional parity support is selected with the SIPO_PARITY_EN macro.
package sipo_pkg;

  // Output buffer occupancy
  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  // Bits per frame on the serial line: data bits plus optional trailing parity bit
  function automatic int unsigned frame_len(input int unsigned width);
`ifdef SIPO_PARITY_EN
    return width + 1;
`else
    return width;
`endif
  endfunction

  // Width of the in-frame bit counter
  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(frame_len(width));
  endfunction

endpackage

// File: rtl/sipo_framer_frame_counter.sv
// frame_counter: counts strobed bits within a frame and flags the final bit.
module frame_counter #(
  parameter int unsigned FL = 8,
  parameter int unsigned CW = (FL > 1) ? $clog2(FL) : 1
) (
  input  logic          clk,
  input  logic          R,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          last
);

  // Frame completes on the strobed edge that samples the final bit
  assign last = en && (cnt == CW'(FL - 1));

  // Bit position within the current frame, wraps after the final bit
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= last ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/sipo_framer.sv
// sipo_framer: serial-in/parallel-out framer, MSB first, with a one-word
// valid/ready output buffer and sticky overrun flag.
// Define SIPO_PARITY_EN to add a trailing even-parity bit per frame and
// report its check on perr; otherwise perr is tied low.
module sipo_framer
  import sipo_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             R,
  input  logic             D,
  input  logic             en,
  input  logic             rdy,
  output logic [WIDTH-1:0] Q,
  output logic             vld,
  output logic             ovf,
  output logic             perr
);

  localparam int unsigned FL = frame_len(WIDTH);
  localparam int unsigned CW = cnt_w(WIDTH);

  logic [CW-1:0]    cnt;
  logic             last;
  logic [WIDTH-1:0] sh;
  logic [WIDTH-1:0] word_c;
  logic             data_c;
  logic             load_c;
  logic             ovf_set_c;
  state_t           state;
  state_t           state_nx;

  frame_counter #(
    .FL (FL),
    .CW (CW)
  ) u_frame_counter (
    .clk  (clk),
    .R    (R),
    .en   (en),
    .cnt  (cnt),
    .last (last)
  );

`ifdef SIPO_PARITY_EN
  logic par;
  logic perr_c;

  // The final bit of a frame is the parity bit and never enters sh
  assign data_c = en && !last;
  assign word_c = sh;
  assign perr_c = par ^ D;

  // Running XOR of the data bits, restarted on the first bit of each frame
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      par <= 1'b0;
    end else if (data_c) begin
      par <= (cnt == '0) ? D : (par ^ D);
    end
  end

  // Parity result travels with the word it belongs to
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      perr <= 1'b0;
    end else if (load_c) begin
      perr <= perr_c;
    end
  end
`else
  logic unused_cnt;

  // Every strobed bit is data; the completing bit is merged straight into the word
  assign data_c     = en;
  assign word_c     = {sh[WIDTH-2:0], D};
  assign perr       = 1'b0;
  assign unused_cnt = ^cnt;
`endif

  // Serial data shifts in MSB first
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      sh <= '0;
    end else if (data_c) begin
      sh <= {sh[WIDTH-2:0], D};
    end
  end

  // Output buffer state register
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nx;
    end
  end

  // Buffer control: accept new words when empty or draining on the same edge
  always_comb begin
    state_nx  = state;
    load_c    = 1'b0;
    ovf_set_c = 1'b0;
    case (state)
      ST_EMPTY: begin
        if (last) begin
          load_c   = 1'b1;
          state_nx = ST_FULL;
        end
      end
      ST_FULL: begin
        if (last) begin
          if (rdy) begin
            load_c = 1'b1;
          end else begin
            ovf_set_c = 1'b1;
          end
        end else if (rdy) begin
          state_nx = ST_EMPTY;
        end
      end
      default: state_nx = ST_EMPTY;
    endcase
  end

  assign vld = (state == ST_FULL);

  // Parallel word register, held stable while waiting for acceptance
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      Q <= '0;
    end else if (load_c) begin
      Q <= word_c;
    end
  end

  // Sticky overrun: a completed word was dropped because the buffer was held
  always_ff @(posedge clk or posedge R) begin
    if (R) begin
      ovf <= 1'b0;
    end else if (ovf_set_c) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sipo_framer.sv
// tb_sipo_framer: directed plus randomized bench for sipo_framer.
// Honors SIPO_PARITY_EN when the design is built with parity.
module tb_sipo_framer;

  localparam int unsigned WIDTH = 8;
`ifdef SIPO_PARITY_EN
  localparam int unsigned PBITS = 1;
`else
  localparam int unsigned PBITS = 0;
`endif
  localparam int unsigned FLM = WIDTH + PBITS;

  logic             clk = 1'b0;
  logic             R;
  logic             D;
  logic             en;
  logic             rdy;
  logic [WIDTH-1:0] Q;
  logic             vld;
  logic             ovf;
  logic             perr;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: bits received in the current frame plus buffer contents
  logic             m_frame[$];
  logic             m_full;
  logic             m_ovf;
  logic             m_perr;
  logic [WIDTH-1:0] m_q;

  logic [WIDTH-1:0] rw;
  logic             rp;

  sipo_framer #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .R    (R),
    .D    (D),
    .en   (en),
    .rdy  (rdy),
    .Q    (Q),
    .vld  (vld),
    .ovf  (ovf),
    .perr (perr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_vld"},  32'(vld),  32'(m_full));
    check({tag, "_q"},    32'(Q),    32'(m_q));
    check({tag, "_ovf"},  32'(ovf),  32'(m_ovf));
    check({tag, "_perr"}, 32'(perr), 32'(m_perr));
  endtask

  task automatic model_reset();
    m_frame.delete();
    m_full = 1'b0;
    m_ovf  = 1'b0;
    m_perr = 1'b0;
    m_q    = '0;
  endtask

  // One clock edge of the reference: collect bits, build the word arithmetically,
  // then apply the buffer rules
  task automatic model_edge(input logic d, input logic e, input logic r);
    logic             done;
    logic [WIDTH-1:0] w;
    logic             pe;
    done = 1'b0;
    w    = '0;
    pe   = 1'b0;
    if (e) begin
      m_frame.push_back(d);
      if (m_frame.size() == FLM) begin
        for (int i = 0; i < int'(WIDTH); i++) w = WIDTH'(w * 2 + WIDTH'(m_frame[i]));
        if (PBITS != 0) pe = (^w) ^ m_frame[WIDTH];
        m_frame.delete();
        done = 1'b1;
      end
    end
    if (!m_full) begin
      if (done) begin
        m_q = w; m_perr = pe; m_full = 1'b1;
      end
    end else if (r) begin
      if (done) begin
        m_q = w; m_perr = pe;
      end else begin
        m_full = 1'b0;
      end
    end else if (done) begin
      m_ovf = 1'b1;
    end
  endtask

  task automatic step(input logic d, input logic e, input logic r);
    R = 1'b0; D = d; en = e; rdy = r;
    @(posedge clk);
    model_edge(d, e, r);
    #1;
    check_outputs("step");
  endtask

  task automatic rst_step(input logic d, input logic e);
    R = 1'b1; D = d; en = e; rdy = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(posedge clk);
    #1;
    check_outputs("rst");
  endtask

  task automatic send_frame(input logic [WIDTH-1:0] word, input logic parbit, input logic gap,
                            input logic r_body, input logic r_last);
    logic b;
    for (int i = 0; i < int'(FLM); i++) begin
      b = (i < int'(WIDTH)) ? word[WIDTH-1-i] : parbit;
      if (gap) step(1'($urandom_range(1, 0)), 1'b0, r_body);
      step(b, 1'b1, (i == int'(FLM) - 1) ? r_last : r_body);
    end
  endtask

  initial begin
    R = 1'b1; D = 1'b0; en = 1'b0; rdy = 1'b0;
    model_reset();

    // Reset held with strobes and toggling data
    for (int i = 0; i < 3; i++) rst_step(1'(i % 2), 1'b1);
    check("rst_q_zero", 32'(Q), 32'h0);
    check("rst_vld_zero", 32'(vld), 32'h0);
    step(1'b0, 1'b0, 1'b1);

    // Basic frame
    send_frame(8'hB2, ^8'hB2, 1'b0, 1'b1, 1'b1);
    check("basic_q", 32'(Q), 32'hB2);
    check("basic_vld", 32'(vld), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    check("basic_vld_drop", 32'(vld), 32'h0);

    // Gapped strobe
    send_frame(8'hB2, ^8'hB2, 1'b1, 1'b1, 1'b1);
    check("gap_q", 32'(Q), 32'hB2);
    check("gap_vld", 32'(vld), 32'h1);
    step(1'b0, 1'b0, 1'b1);

    // Backpressure and overrun
    send_frame(8'hA5, ^8'hA5, 1'b0, 1'b0, 1'b0);
    check("bp_q1", 32'(Q), 32'hA5);
    check("bp_ovf1", 32'(ovf), 32'h0);
    send_frame(8'h3C, ^8'h3C, 1'b0, 1'b0, 1'b0);
    check("bp_q2", 32'(Q), 32'hA5);
    check("bp_ovf2", 32'(ovf), 32'h1);
    step(1'b0, 1'b0, 1'b1);
    check("bp_drain_vld", 32'(vld), 32'h0);
    check("bp_ovf_sticky", 32'(ovf), 32'h1);
    rst_step(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);

    // Accept and complete on the same edge
    send_frame(8'hF0, ^8'hF0, 1'b0, 1'b0, 1'b0);
    send_frame(8'h0F, ^8'h0F, 1'b0, 1'b0, 1'b1);
    check("sim_vld", 32'(vld), 32'h1);
    check("sim_q", 32'(Q), 32'h0F);
    check("sim_ovf", 32'(ovf), 32'h0);
    step(1'b0, 1'b0, 1'b1);

    // Reset in the middle of a frame
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1);
    rst_step(1'b1, 1'b1);
    send_frame(8'h81, ^8'h81, 1'b0, 1'b1, 1'b1);
    check("midrst_q", 32'(Q), 32'h81);
    step(1'b0, 1'b0, 1'b1);

`ifdef SIPO_PARITY_EN
    send_frame(8'h81, 1'b0, 1'b0, 1'b1, 1'b1);
    check("par_good", 32'(perr), 32'h0);
    step(1'b0, 1'b0, 1'b1);
    send_frame(8'h81, 1'b1, 1'b0, 1'b1, 1'b1);
    check("par_bad", 32'(perr), 32'h1);
    step(1'b0, 1'b0, 1'b1);
`endif

    // Randomized traffic: random words, strobe gaps, ready and parity errors
    rst_step(1'b0, 1'b0);
    for (int f = 0; f < 150; f++) begin
      rw = WIDTH'($urandom);
      rp = (^rw) ^ ($urandom_range(3, 0) == 0);
      for (int i = 0; i < int'(FLM); i++) begin
        while ($urandom_range(2, 0) == 0) step(1'($urandom_range(1, 0)), 1'b0, 1'($urandom_range(1, 0)));
        step((i < int'(WIDTH)) ? rw[WIDTH-1-i] : rp, 1'b1, 1'($urandom_range(1, 0)));
      end
      if ($urandom_range(19, 0) == 0) rst_step(1'($urandom_range(1, 0)), 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
